// File: rtl/alu_wide_sequencer.sv
// Byte-serial driver/collector around an 8-bit ALU: wide operands in, one byte per cycle LSB first
// with chained carry, whole-word result and locally computed flags out. Optional: ALU_SEQ_FLUSH_EN.
module alu_wide_sequencer #(
    parameter int unsigned BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] in_a,
    input  logic [8*BYTES-1:0] in_b,
    input  logic [3:0]         in_op,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] out_result,
    output logic               out_cout,
    output logic               out_zero,
    output logic               out_negative,
    output logic               out_overflow,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_op,
    output logic               alu_cin,
    input  logic [7:0]         alu_result,
    input  logic               alu_cout
);

    localparam int unsigned W    = 8 * BYTES;
    localparam logic [2:0]  LAST = 3'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [3:0]     op_q;
    logic           carry_q;
    logic [2:0]     idx_q;
    logic [W-1:0]   work_q;
    logic [W-1:0]   res_d;
    logic           out_valid_q;
    logic [W-1:0]   result_q;
    logic           cout_q;
    logic           zero_q;
    logic           neg_q;
    logic           ovf_q;

    // Bytes are gathered in work_q so out_result only changes when a full word completes.
    always_comb begin
        res_d = work_q;
        res_d[8*idx_q +: 8] = alu_result;
    end

`ifdef ALU_SEQ_FLUSH_EN
    assign in_ready = (state_q == IDLE) && !flush;
`else
    assign in_ready = (state_q == IDLE);
`endif

    always_comb begin
        alu_op  = op_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if (state_q == RUN) begin
            alu_a   = a_q[8*idx_q +: 8];
            alu_b   = b_q[8*idx_q +: 8];
            alu_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end
`ifdef ALU_SEQ_FLUSH_EN
        else if (flush && state_q != IDLE) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= in_op;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q  <= res_d;
                    carry_q <= alu_cout;
                    idx_q   <= idx_q + 3'd1;
                    if (idx_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= res_d;
                        cout_q      <= alu_cout;
                        zero_q      <= (res_d == '0);
                        neg_q       <= res_d[W-1];
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = result_q;
    assign out_cout     = cout_q;
    assign out_zero     = zero_q;
    assign out_negative = neg_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Scoreboard bench for alu_wide_sequencer with an 8-bit adder standing in for the ALU.
module tb_alu_wide_sequencer;

    localparam int unsigned BYTES = 4;
    localparam int unsigned W     = 8 * BYTES;

    logic         clk = 1'b0;
    logic         rst;
`ifdef ALU_SEQ_FLUSH_EN
    logic         flush;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_op;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         out_zero;
    logic         out_negative;
    logic         out_overflow;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic [3:0]   alu_op;
    logic         alu_cin;
    logic [7:0]   alu_result;
    logic         alu_cout;

    alu_wide_sequencer #(.BYTES(BYTES)) dut (
        .clk(clk), .rst(rst),
`ifdef ALU_SEQ_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cout(out_cout), .out_zero(out_zero), .out_negative(out_negative),
        .out_overflow(out_overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t exp_q[$];
    time  acc_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   rand_ready = 1'b0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Whole-word reference: plain wide addition and the flag rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        logic [W:0] s;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.r = s[W-1:0];
        e.c = s[W];
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        time  t;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) fail("unexpected_out_valid");
                else begin
                    t = acc_q.pop_front();
                    chk("latency", 64'(($time - t - 5) / 10), 64'(BYTES));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail("unexpected_result");
                else begin
                    e = exp_q.pop_front();
                    chk("result",   64'(out_result),   64'(e.r));
                    chk("cout",     64'(out_cout),     64'(e.c));
                    chk("zero",     64'(out_zero),     64'(e.z));
                    chk("negative", 64'(out_negative), 64'(e.n));
                    chk("overflow", 64'(out_overflow), 64'(e.v));
                end
            end
            prev_valid = out_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [3:0] op);
        int n = 0;
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(a, b, cin));
        @(posedge clk);
        acc_q.push_back($time);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !in_ready) fail("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cap_r;
        logic [3:0]   cap_f;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        time          tnow;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_SEQ_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),   64'd1);
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_result",    64'(out_result), 64'd0);
        chk("rst_flags", 64'({out_cout, out_zero, out_negative, out_overflow}), 64'd0);
        chk("idle_alu_a",   64'(alu_a),   64'd0);
        chk("idle_alu_cin", 64'(alu_cin), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 4'h3);
        @(negedge clk);
        chk("byte0_alu_a",   64'(alu_a),   64'hFF);
        chk("byte0_alu_cin", 64'(alu_cin), 64'd0);
        chk("alu_op",        64'(alu_op),  64'h3);
        @(negedge clk);
        chk("byte1_alu_cin", 64'(alu_cin), 64'd1);
        chk("byte1_alu_a",   64'(alu_a),   64'd0);
        wait_drain();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h0); wait_drain();
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 4'h0); wait_drain();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h0); wait_drain();
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 4'h0); wait_drain();

        // Backpressure with a competing request held
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h0000_1234, 32'h0000_0F0F, 1'b1, 4'h5);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        if (!out_valid) fail("bp_valid_timeout");
        cap_r = out_result;
        cap_f = {out_cout, out_zero, out_negative, out_overflow};
        in_a = 32'hAAAA_5555; in_b = 32'h1111_2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result_stable", 64'(out_result), 64'(cap_r));
            chk("bp_flags_stable",
                64'({out_cout, out_zero, out_negative, out_overflow}), 64'(cap_f));
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready",  64'(in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        tnow = $time;
        send(32'hAAAA_5555, 32'h1111_2222, 1'b0, 4'h1);
        chk("bp_next_accept_delay", 64'(acc_q[acc_q.size()-1] - tnow), 64'd5);
        wait_drain();

        // Reset two cycles into RUN
        send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 4'h2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid),  64'd0);
        chk("midrst_in_ready",  64'(in_ready),   64'd1);
        chk("midrst_result",    64'(out_result), 64'd0);
        chk("midrst_flags", 64'({out_cout, out_zero, out_negative, out_overflow}), 64'd0);
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 4'h0);
        wait_drain();

`ifdef ALU_SEQ_FLUSH_EN
        cap_r = out_result;
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("flush_out_valid",    64'(out_valid), 64'd0);
        chk("flush_gates_ready",  64'(in_ready),  64'd0);
        flush = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        for (int i = 0; i < int'(BYTES) + 2; i++) begin
            @(negedge clk);
            chk("flush_no_valid", 64'(out_valid), 64'd0);
        end
        chk("flush_keeps_result", 64'(out_result), 64'(cap_r));
        flush = 1'b1; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1;
        repeat (3) @(negedge clk);
        chk("flush_idle_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (BYTES + 2) @(negedge clk);
        chk("flush_idle_no_accept", 64'(out_valid), 64'd0);
`endif

        // Randomised traffic with random consumer stalls
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < int'(BYTES); j++) begin
                ra[8*j +: 8] = 8'($urandom);
                rb[8*j +: 8] = 8'($urandom);
            end
            case ($urandom_range(0, 5))
                0: ra = '1;
                1: rb = '0;
                2: begin ra = {1'b0, {(W-1){1'b1}}}; rb = W'(1); end
                default: ;
            endcase
            send(ra, rb, 1'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
